// File: rtl/lc4_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained by execute-stage resolutions. `LC4_BP_STATS_EN adds resolve/mispredict counters.
module lc4_branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gwe,
    input  logic [15:0] fetch_pc,
    output logic        pred_taken,
    output logic [15:0] pred_pc,
    input  logic        resolve_valid,
    input  logic [15:0] resolve_pc,
    input  logic        resolve_is_branch,
    input  logic        resolve_taken,
    input  logic [15:0] resolve_target,
    input  logic [15:0] resolve_pred_pc,
    output logic        mispredict,
    output logic [15:0] redirect_pc
`ifdef LC4_BP_STATS_EN
    ,
    output logic [15:0] stat_resolved,
    output logic [15:0] stat_mispredicts
`endif
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 16 - INDEX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [15:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic               mispredict_q, mispredict_d;
    logic [15:0]        redirect_pc_q, redirect_pc_d;

    // Lookup
    logic [INDEX_BITS-1:0] f_idx;
    logic                  f_hit;

    assign f_idx      = fetch_pc[INDEX_BITS-1:0];
    assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == fetch_pc[15:INDEX_BITS]);
    assign pred_taken = f_hit && ctr_q[f_idx][1];
    assign pred_pc    = pred_taken ? tgt_q[f_idx] : fetch_pc + 16'd1;

    // Training: only the entry at r_idx can change on a given edge
    logic [INDEX_BITS-1:0] r_idx;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_hit;
    logic                  upd;
    logic [15:0]           actual_pc;
    logic                  ent_we_d;
    logic [TAG_W-1:0]      ent_tag_d;
    logic [15:0]           ent_tgt_d;
    logic [1:0]            ent_ctr_d;

    assign r_idx     = resolve_pc[INDEX_BITS-1:0];
    assign r_tag     = resolve_pc[15:INDEX_BITS];
    assign r_hit     = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign upd       = resolve_valid && gwe;
    assign actual_pc = resolve_taken ? resolve_target : resolve_pc + 16'd1;

    always_comb begin
        ent_we_d  = 1'b0;
        ent_tag_d = r_tag;
        ent_tgt_d = tgt_q[r_idx];
        ent_ctr_d = ctr_q[r_idx];
        if (upd) begin
            if (r_hit && resolve_is_branch) begin
                ent_we_d = 1'b1;
                if (resolve_taken) begin
                    ent_ctr_d = (ctr_q[r_idx] == 2'b11) ? 2'b11 : ctr_q[r_idx] + 2'd1;
                    ent_tgt_d = resolve_target;
                end else begin
                    ent_ctr_d = (ctr_q[r_idx] == 2'b00) ? 2'b00 : ctr_q[r_idx] - 2'd1;
                end
            end else if (r_hit) begin
                ent_we_d  = 1'b1;
                ent_ctr_d = 2'b11;
                ent_tgt_d = resolve_target;
            end else if (resolve_taken) begin
                // Allocation evicts whatever alias occupied this index
                ent_we_d  = 1'b1;
                ent_tgt_d = resolve_target;
                ent_ctr_d = resolve_is_branch ? 2'b10 : 2'b11;
            end
        end
    end

    always_comb begin
        mispredict_d  = mispredict_q;
        redirect_pc_d = redirect_pc_q;
        if (upd) begin
            mispredict_d  = (actual_pc != resolve_pred_pc);
            redirect_pc_d = actual_pc;
        end else if (gwe) begin
            mispredict_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b00;
            end
        end else if (ent_we_d) begin
            valid_q[r_idx] <= 1'b1;
            tag_q[r_idx]   <= ent_tag_d;
            tgt_q[r_idx]   <= ent_tgt_d;
            ctr_q[r_idx]   <= ent_ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= 16'h0000;
        end else begin
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;

`ifdef LC4_BP_STATS_EN
    logic [15:0] stat_resolved_q, stat_resolved_d;
    logic [15:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mis_d      = stat_mis_q;
        if (upd) begin
            stat_resolved_d = stat_resolved_q + 16'd1;
            if (mispredict_d) stat_mis_d = stat_mis_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_q <= 16'h0000;
            stat_mis_q      <= 16'h0000;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mis_q      <= stat_mis_d;
        end
    end

    assign stat_resolved    = stat_resolved_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_lc4_branch_predictor.sv
// Bench for lc4_branch_predictor: directed test-plan steps followed by random
// traffic, all checked against a small table model of the predictor's rules.
module tb_lc4_branch_predictor;
    localparam int ENT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gwe;
    logic [15:0] fetch_pc;
    logic        pred_taken;
    logic [15:0] pred_pc;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_is_branch;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic [15:0] resolve_pred_pc;
    logic        mispredict;
    logic [15:0] redirect_pc;
`ifdef LC4_BP_STATS_EN
    logic [15:0] stat_resolved, stat_mispredicts;
`endif

    lc4_branch_predictor #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .gwe(gwe),
        .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_is_branch(resolve_is_branch), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_pred_pc(resolve_pred_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef LC4_BP_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-slot entry, counter kept as an integer strength 0..3
    bit          m_valid [ENT];
    int          m_tag   [ENT];
    logic [15:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    logic        m_mis;
    logic [15:0] m_red;
    int          m_nres, m_nmis;

    int pass_cnt = 0;
    int total    = 0;

    function automatic bit m_hit(logic [15:0] pc);
        return m_valid[pc % ENT] && m_tag[pc % ENT] == int'(pc / ENT);
    endfunction

    function automatic logic [15:0] m_pred(logic [15:0] pc);
        if (m_hit(pc) && m_ctr[pc % ENT] >= 2) return m_tgt[pc % ENT];
        return pc + 16'd1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 16'h0; m_ctr[i] = 0;
        end
        m_mis = 1'b0; m_red = 16'h0; m_nres = 0; m_nmis = 0;
    endtask

    task automatic m_edge();
        int i;
        logic [15:0] actual;
        bit hit;
        if (!gwe) return;
        if (!resolve_valid) begin
            m_mis = 1'b0;
            return;
        end
        i      = resolve_pc % ENT;
        hit    = m_hit(resolve_pc);
        actual = resolve_taken ? resolve_target : resolve_pc + 16'd1;
        if (hit && resolve_is_branch) begin
            m_ctr[i] = resolve_taken ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                                     : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
            if (resolve_taken) m_tgt[i] = resolve_target;
        end else if (hit) begin
            m_ctr[i] = 3;
            m_tgt[i] = resolve_target;
        end else if (resolve_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = resolve_pc / ENT;
            m_tgt[i]   = resolve_target;
            m_ctr[i]   = resolve_is_branch ? 2 : 3;
        end
        m_mis = (actual != resolve_pred_pc);
        m_red = actual;
        m_nres++;
        if (m_mis) m_nmis++;
    endtask

    task automatic chk(input string t, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h want %h", t, obs, exp);
    endtask

    task automatic drive(input logic [15:0] fpc, input logic rv, input logic [15:0] rpc,
                         input logic br, input logic tk, input logic [15:0] tgt,
                         input logic [15:0] rpp, input logic g);
        fetch_pc = fpc; resolve_valid = rv; resolve_pc = rpc; resolve_is_branch = br;
        resolve_taken = tk; resolve_target = tgt; resolve_pred_pc = rpp; gwe = g;
    endtask

    // Called at a negedge with inputs applied: check lookup, clock once, check registers
    task automatic step(input string t);
        #1;
        chk({t, ".pred_taken"}, {15'd0, pred_taken}, {15'd0, m_pred(fetch_pc) != fetch_pc + 16'd1});
        chk({t, ".pred_pc"}, pred_pc, m_pred(fetch_pc));
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk({t, ".mispredict"}, {15'd0, mispredict}, {15'd0, m_mis});
        chk({t, ".redirect_pc"}, redirect_pc, m_red);
    endtask

    logic [15:0] pool [6];

    initial begin
        m_reset();
        rst_n = 1'b0;
        drive(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1;
        chk("rst.pred_taken", {15'd0, pred_taken}, 16'h0000);
        chk("rst.pred_pc", pred_pc, 16'h0011);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.mispredict", {15'd0, mispredict}, 16'h0000);
        chk("rst.redirect_pc", redirect_pc, 16'h0000);
        @(negedge clk);

        // Cold miss allocation
        drive(16'h0010, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0040, 16'h0011, 1'b1);
        step("cold");
        chk("cold.redirect_const", redirect_pc, 16'h0040);
        drive(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 chk("cold.pred_const", pred_pc, 16'h0040);
        step("cold_idle");

        // Training down to strong-NT and back
        for (int k = 0; k < 4; k++) begin
            drive(16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, m_pred(16'h0010), 1'b1);
            step("train_nt");
        end
        chk("train.ctr_floor_pred", pred_pc, 16'h0011);
        for (int k = 0; k < 2; k++) begin
            drive(16'h0010, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0040, m_pred(16'h0010), 1'b1);
            step("train_t");
        end
        #1 chk("train.retaken_pred", pred_pc, 16'h0040);

        // Alias at index 3 and wrap
        drive(16'h0013, 1'b1, 16'h0013, 1'b1, 1'b1, 16'h0100, 16'h0014, 1'b1);
        step("alias_a");
        drive(16'h0013, 1'b1, 16'h0023, 1'b1, 1'b1, 16'h0200, 16'h0024, 1'b1);
        step("alias_b");
        drive(16'h0013, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 chk("alias.evicted_pc", pred_pc, 16'h0014);
        step("alias_fetch");
        drive(16'hFFFF, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 chk("wrap.pred_pc", pred_pc, 16'h0000);
        step("wrap");

        // gwe=0: force a pending mispredict first, then a blocked miss allocation
        drive(16'h0050, 1'b1, 16'h0050, 1'b1, 1'b1, 16'h0070, 16'h0051, 1'b1);
        step("gwe_pre");
        drive(16'h0066, 1'b1, 16'h0066, 1'b1, 1'b1, 16'h0123, 16'h0067, 1'b0);
        step("gwe_off");
        chk("gwe_off.mis_hold", {15'd0, mispredict}, 16'h0001);
        drive(16'h0066, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 chk("gwe_off.no_alloc", pred_pc, 16'h0067);
        step("gwe_after");

        // Read-before-write on the same index
        drive(16'h0088, 1'b1, 16'h0088, 1'b0, 1'b1, 16'h0300, 16'h0089, 1'b1);
        #1 chk("rbw.old", pred_pc, 16'h0089);
        step("rbw");
        drive(16'h0088, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 chk("rbw.new", pred_pc, 16'h0300);
        step("rbw_next");

        // Random traffic over a small PC pool to force hits and aliases
        pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h0013;
        pool[3] = 16'h0023; pool[4] = 16'hFFFF; pool[5] = 16'h0045;
        for (int n = 0; n < 400; n++) begin
            logic [15:0] rpc, fpc, rpp;
            rpc = pool[$urandom_range(5)];
            fpc = ($urandom_range(3) == 0) ? rpc : pool[$urandom_range(5)];
            rpp = $urandom_range(1) ? m_pred(rpc) : rpc + 16'd1;
            drive(fpc, 1'($urandom_range(3) != 0), rpc, 1'($urandom_range(3) != 0),
                  1'($urandom_range(1)), 16'($urandom), rpp, 1'($urandom_range(7) != 0));
            step("rand");
        end

`ifdef LC4_BP_STATS_EN
        chk("stat_resolved", stat_resolved, 16'(m_nres));
        chk("stat_mispredicts", stat_mispredicts, 16'(m_nmis));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/lc4_branch_predictor.md
Name: lc4_branch_predictor

Overview:
Fetch-side counterpart to the execute-stage branch resolution logic. It predicts `next_pc` for the fetch PC using a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. Resolved outcomes (taken flag, target, `pc+1`) from execute train the table. A registered mispredict/redirect pulse tells fetch to flush and restart.

Parameters:
INDEX_BITS, 4, BTB index width; ENTRIES = 2^INDEX_BITS; tag width = 16-INDEX_BITS (PC[15:INDEX_BITS]).

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous reset, active-low
gwe  input  1  global write enable; all state updates qualified by gwe=1
fetch_pc  input  16  PC being fetched this cycle
pred_taken  output  1  combinational: BTB hit and counter[1]=1
pred_pc  output  16  combinational: BTB target if pred_taken, else fetch_pc+1
resolve_valid  input  1  execute stage holds a resolved control insn this cycle
resolve_pc  input  16  PC of the resolved insn
resolve_is_branch  input  1  conditional branch (counter trains normally)
resolve_taken  input  1  actual branch_taken from execute
resolve_target  input  16  actual branch/jump target
resolve_pred_pc  input  16  pred_pc carried down the pipe with this insn
mispredict  output  1  registered: one-cycle pulse, previous resolve was mispredicted
redirect_pc  output  16  registered: correct next PC accompanying mispredict

Behaviour:
- Storage per entry: valid, tag, 16-bit target, 2-bit counter. Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst_n=0, async):
  - All valid bits 0, counters 00, targets 0.
  - mispredict=0, redirect_pc=16'h0000.
  - The table is cleared even if reset lands mid-update.
- Lookup (combinational):
  - idx = fetch_pc[INDEX_BITS-1:0].
  - hit = valid[idx] and tag[idx] == fetch_pc[15:INDEX_BITS].
  - fetch_pc+1 wraps modulo 2^16 (16'hFFFF gives 16'h0000).
- Actual next PC: actual_pc = resolve_taken ? resolve_target : resolve_pc+1 (same 16-bit wrap).
- Update on rising clk when resolve_valid & gwe:
  - Hit on resolve_pc, is_branch=1: counter increments (saturate at 11) if taken, decrements (saturate at 00) if not taken. Target overwritten only when taken.
  - Hit, is_branch=0 (unconditional control): counter := 11, target := resolve_target.
  - Miss and resolve_taken=1: allocate and overwrite the entry. valid=1, tag set, target=resolve_target; counter = 10 if is_branch, 11 otherwise.
  - Miss and resolve_taken=0: no change.
- Mispredict register, same edge, qualified by resolve_valid & gwe:
  - mispredict := (actual_pc != resolve_pred_pc).
  - redirect_pc := actual_pc.
  - Otherwise mispredict := 0 and redirect_pc holds.
- gwe=0: no table, mispredict, redirect, or stats change; mispredict holds its value.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-before-write). The new contents are visible the next cycle.
- Aliasing: a different tag at the same index is a miss. Allocation replaces the old entry.

Optional Feature:
LC4_BP_STATS_EN:
- When defined, adds two outputs:
  - stat_resolved [15:0]: counts resolve_valid&gwe cycles.
  - stat_mispredicts [15:0]: counts cycles where mispredict is set.
- Both counters wrap at 16'hFFFF, reset to 0, and are gated by gwe.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then fetch_pc=16'h0010 -> pred_taken=0, pred_pc=16'h0011; after reset release mispredict=0, redirect_pc=0.
- Cold miss:
  - Resolve pc=16'h0010, is_branch=1, taken=1, target=16'h0040, pred_pc=16'h0011 -> next cycle mispredict=1, redirect_pc=16'h0040.
  - Then fetch 16'h0010 -> pred_taken=1, pred_pc=16'h0040 (counter 10).
- Training:
  - Starting at counter 10, resolve 16'h0010 not-taken twice, with resolve_pred_pc equal to the current prediction each time.
  - First resolve -> mispredict=1, redirect_pc=16'h0011.
  - Second resolve -> mispredict=0; prediction becomes pc+1 after the first; counter reaches 00.
  - Two more not-taken resolves keep it at 00; it takes two taken resolves to predict taken again.
- Alias and wrap:
  - Allocate pc=16'h0013 -> 16'h0100, then resolve pc=16'h0023 (same idx) taken -> 16'h0200.
  - Fetch 16'h0013 -> miss, pred_pc=16'h0014.
  - Fetch 16'hFFFF -> pred_pc=16'h0000.
- gwe=0 with resolve_valid=1, taken, on a miss -> no allocation, mispredict unchanged.
- Same-cycle lookup/update on the same idx -> old prediction that cycle, new one the next; with LC4_BP_STATS_EN, stat_resolved/stat_mispredicts match a scoreboard count across all prior scenarios.
